// File: rtl/lru_tracker.sv
// Recency list of panel channel IDs with move-to-front on hit,
// eviction of the oldest entry when full, and one update per press.
module lru_tracker #(
    parameter int N_CH  = 4,
    parameter int DEPTH = 3,
    parameter int ID_W  = $clog2(N_CH + 1),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             timedClk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    input  logic             flush,
    output logic [N_CH-1:0]  present,
    output logic [CNT_W-1:0] count,
    output logic [ID_W-1:0]  mru_id,
    output logic [ID_W-1:0]  lru_id,
    output logic             hit,
    output logic             evict_valid,
    output logic [ID_W-1:0]  evict_id
);

    typedef enum logic [1:0] {IDLE, UPDATE, WAIT_REL} state_t;

    state_t          state;
    logic [ID_W-1:0] sel;
    logic [ID_W-1:0] slots [DEPTH];

    logic [ID_W-1:0]  req_id;
    logic [ID_W-1:0]  nxt [DEPTH];
    logic             hit_n;
    int               hit_k;
    logic             evict_n;
    logic [CNT_W-1:0] cnt_n;
    logic [ID_W-1:0]  evid_n;
    logic [N_CH-1:0]  pres_n;
    logic [ID_W-1:0]  lru_n;

    // Lowest-index request wins
    always_comb begin
        req_id = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[i]) req_id = ID_W'(i + 1);
        end
    end

    always_comb begin
        hit_n = 1'b0;
        hit_k = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!hit_n && slots[k] == sel) begin
                hit_n = 1'b1;
                hit_k = k;
            end
        end
        nxt[0] = sel;
        for (int j = 1; j < DEPTH; j++) begin
            nxt[j] = (!hit_n || j <= hit_k) ? slots[j-1] : slots[j];
        end
        evict_n = !hit_n && (count == CNT_W'(DEPTH));
        cnt_n   = (hit_n || evict_n) ? count : count + 1'b1;
        evid_n  = evict_n ? slots[DEPTH-1] : '0;
        pres_n  = '0;
        for (int i = 0; i < N_CH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (nxt[j] == ID_W'(i + 1)) pres_n[i] = 1'b1;
            end
        end
        lru_n = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (CNT_W'(j + 1) == cnt_n) lru_n = nxt[j];
        end
    end

    always_ff @(posedge timedClk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= '0;
            for (int j = 0; j < DEPTH; j++) slots[j] <= '0;
            count       <= '0;
            present     <= '0;
            mru_id      <= '0;
            lru_id      <= '0;
            hit         <= 1'b0;
            evict_valid <= 1'b0;
            evict_id    <= '0;
        end else begin
            hit         <= 1'b0;
            evict_valid <= 1'b0;
            evict_id    <= '0;
            if (flush) begin
                state   <= WAIT_REL;
                sel     <= '0;
                for (int j = 0; j < DEPTH; j++) slots[j] <= '0;
                count   <= '0;
                present <= '0;
                mru_id  <= '0;
                lru_id  <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (|req) begin
                            sel   <= req_id;
                            state <= UPDATE;
                        end
                    end
                    UPDATE: begin
                        for (int j = 0; j < DEPTH; j++) slots[j] <= nxt[j];
                        count       <= cnt_n;
                        present     <= pres_n;
                        mru_id      <= sel;
                        lru_id      <= lru_n;
                        hit         <= hit_n;
                        evict_valid <= evict_n;
                        evict_id    <= evid_n;
                        state       <= WAIT_REL;
                    end
                    WAIT_REL: begin
                        if (!(|req)) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lru_tracker.sv
// Directed and random press sequences against a queue model of the
// recency list; second instance covers the full-depth configuration.
module tb_lru_tracker;

    logic       timedClk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       flush;
    logic [3:0] present;
    logic [1:0] count;
    logic [2:0] mru_id, lru_id, evict_id;
    logic       hit, evict_valid;

    logic [7:0] req2;
    logic       flush2;
    logic [7:0] present2;
    logic [3:0] count2;
    logic [3:0] mru2, lru2, evid2;
    logic       hit2, ev2;

    int vectors = 0;
    int miscompares = 0;
    int q[$];

    always #5 timedClk = ~timedClk;

    lru_tracker #(.N_CH(4), .DEPTH(3)) dut (
        .timedClk(timedClk), .rst(rst), .req(req), .flush(flush),
        .present(present), .count(count), .mru_id(mru_id),
        .lru_id(lru_id), .hit(hit), .evict_valid(evict_valid),
        .evict_id(evict_id)
    );

    lru_tracker #(.N_CH(8), .DEPTH(8)) dut8 (
        .timedClk(timedClk), .rst(rst), .req(req2), .flush(flush2),
        .present(present2), .count(count2), .mru_id(mru2),
        .lru_id(lru2), .hit(hit2), .evict_valid(ev2),
        .evict_id(evid2)
    );

    task automatic tick();
        @(posedge timedClk);
        @(negedge timedClk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_list(input bit eh, input bit ee, input int eid);
        logic [3:0] pm;
        pm = '0;
        foreach (q[i]) pm[q[i]-1] = 1'b1;
        check("present", present, pm);
        check("count", count, q.size());
        check("mru", mru_id, q.size() ? q[0] : 0);
        check("lru", lru_id, q.size() ? q[q.size()-1] : 0);
        check("hit", hit, eh);
        check("evict_valid", evict_valid, ee);
        check("evict_id", evict_id, eid);
    endtask

    task automatic model_press(input int id, output bit eh,
                               output bit ee, output int eid);
        eh = 1'b0;
        ee = 1'b0;
        eid = 0;
        foreach (q[i]) begin
            if (q[i] == id) begin
                eh = 1'b1;
                q.delete(i);
                break;
            end
        end
        q.push_front(id);
        if (q.size() > 3) begin
            ee = 1'b1;
            eid = q.pop_back();
        end
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        int id;
        bit eh, ee;
        int eid;
        id = 0;
        for (int i = 3; i >= 0; i--) if (mask[i]) id = i + 1;
        model_press(id, eh, ee, eid);
        req = mask;
        tick();
        tick();
        check_list(eh, ee, eid);
        for (int h = 0; h < hold; h++) begin
            tick();
            check_list(1'b0, 1'b0, 0);
        end
        req = '0;
        tick();
        check_list(1'b0, 1'b0, 0);
    endtask

    initial begin
        int p[8];
        logic [7:0] m8;
        rst = 1'b1;
        req = '0;
        flush = 1'b0;
        req2 = '0;
        flush2 = 1'b0;
        @(negedge timedClk);
        @(negedge timedClk);
        check_list(1'b0, 1'b0, 0);
        rst = 1'b0;
        tick();

        press(4'b0001, 0);
        press(4'b0010, 1);
        press(4'b0100, 0);
        check("full_present", present, 4'b0111);
        press(4'b1000, 0);
        check("evicted_present", present, 4'b1110);
        press(4'b0010, 0);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        q.delete();
        check_list(1'b0, 1'b0, 0);
        tick();
        press(4'b0100, 9);
        press(4'b1010, 0);

        req = 4'b0001;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        q.delete();
        check_list(1'b0, 1'b0, 0);
        tick();
        tick();
        check_list(1'b0, 1'b0, 0);
        req = '0;
        tick();
        press(4'b0100, 0);
        press(4'b0001, 0);

        req = 4'b1000;
        @(posedge timedClk);
        #2 rst = 1'b1;
        #1;
        q.delete();
        check_list(1'b0, 1'b0, 0);
        req = '0;
        @(negedge timedClk);
        rst = 1'b0;
        tick();
        check_list(1'b0, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            press(4'($urandom_range(15, 1)), $urandom_range(2, 0));
        end

        for (int i = 0; i < 8; i++) p[i] = i + 1;
        for (int i = 7; i > 0; i--) begin
            int j, t;
            j = $urandom_range(i, 0);
            t = p[i];
            p[i] = p[j];
            p[j] = t;
        end
        m8 = '0;
        for (int i = 0; i < 8; i++) begin
            req2 = 8'(1) << (p[i] - 1);
            m8[p[i]-1] = 1'b1;
            tick();
            tick();
            check("d8_count", count2, i + 1);
            check("d8_evict", ev2, 0);
            check("d8_mru", mru2, p[i]);
            check("d8_lru", lru2, p[0]);
            check("d8_present", present2, m8);
            req2 = '0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lru_tracker.md
# lru_tracker

Parametrised least-recently-used tracker for the button/LED panel, successor to the fixed 4-button, 3-entry push queue. It takes N_CH request lines, keeps an ordered recency list of up to DEPTH distinct channel IDs, and drives a per-channel presence vector (LEDs), MRU/LRU IDs, occupancy and a one-cycle eviction report. Unlike the previous block, it:

- de-duplicates IDs on a hit (move-to-front);
- accepts exactly one update per press;
- supports a synchronous flush.

## Interface

Parameters:
- N_CH, 4: number of request channels; IDs are 1..N_CH, ID 0 = empty slot; N_CH >= 2
- DEPTH, 3: recency list slots; 1 <= DEPTH <= N_CH
- ID_W, $clog2(N_CH+1): ID width (derived, not overridden)
- CNT_W, $clog2(DEPTH+1): occupancy width (derived)

Ports:
- timedClk  in  1  clock (already divided by the panel timer)
- rst  in  1  asynchronous, active-high reset
- req  in  N_CH  request lines; bit i = channel ID i+1; level, held while pressed
- flush  in  1  synchronous clear of the list
- present  out  N_CH  bit i high when ID i+1 is in the list (LED drive)
- count  out  CNT_W  valid entries, 0..DEPTH
- mru_id  out  ID_W  slot 0 ID; 0 when empty
- lru_id  out  ID_W  slot count-1 ID; 0 when empty
- hit  out  1  one-cycle pulse: last update found the ID already listed
- evict_valid  out  1  one-cycle pulse: last update dropped an entry
- evict_id  out  ID_W  dropped ID, valid with evict_valid, else 0

## Operation

- Storage: DEPTH slots of ID_W bits, slot 0 = MRU. Valid slots are always contiguous from slot 0; slots >= count hold 0.
- All outputs are registered.
- Reset values: slots 0, count 0, present 0, mru_id 0, lru_id 0, hit 0, evict_valid 0, evict_id 0, state IDLE.
- FSM states: IDLE, UPDATE, WAIT_REL.
  - IDLE: if req != 0, latch sel = lowest set bit index + 1 and go to UPDATE. Otherwise stay.
  - UPDATE: apply the update for sel, then go to WAIT_REL unconditionally.
  - WAIT_REL: stay until req == 0, then go to IDLE. Holding a button never produces a second update.
- Update rules for sel:
  - Hit, sel in slot k: slots 0..k-1 shift down one, sel goes to slot 0. count is unchanged. hit=1.
  - Miss, count < DEPTH: all valid slots shift down one, sel goes to slot 0. count+1.
  - Miss, count == DEPTH: the slot DEPTH-1 ID is dropped, the rest shift, sel goes to slot 0. evict_valid=1, evict_id = dropped ID, count unchanged.
- hit, evict_valid and evict_id return to 0 on the following edge.
- present, mru_id and lru_id are recomputed from the post-update list and registered together with it.
- Simultaneous requests: the lowest index wins. Other bits are ignored until all requests are released.
- flush: in any state, flush clears all slots, count, present, mru_id, lru_id, hit, evict_valid and evict_id, and sets state to WAIT_REL. flush has priority over UPDATE; a latched sel is discarded.
- DEPTH == N_CH: eviction is unreachable; evict_valid stays 0.

## Timing

- Edge E0: IDLE samples req != 0, latches sel.
- Edge E1: list, count, present, mru_id, lru_id, hit, evict_* are updated. They are visible from E1 until the next edge.
- Press-to-LED latency is 2 edges from the first edge where req is seen high.
- Pulses (hit, evict_valid) are exactly 1 timedClk cycle wide.
- Minimum press-to-press: release must be seen in WAIT_REL, giving 3 edges per press minimum.
- rst mid-UPDATE: the update is lost. All outputs go to reset values immediately (async), with no clock needed.
- req glitches shorter than one timedClk period are not filtered beyond sampling.

## Test plan

Defaults N_CH=4, DEPTH=3.

1. Reset then press req=0001, release → present=0001, count=1, mru_id=1, lru_id=1, hit=0, evict_valid=0.
2. Press 1, 2, 3 (release between each) → present=0111, mru=3, lru=1, count=3. Then press 4 → evict_valid pulse with evict_id=1, present=1110, mru=4, lru=2.
3. With list [4,3,2], press 2 → hit pulse, list [2,4,3], present unchanged, count=3, evict_valid=0.
4. Hold req=0100 for 10 edges from empty → exactly one update: count=1, no second hit pulse. Also req=1010 pressed together → only ID 2 inserted.
5. flush asserted in the same edge UPDATE would commit → list empty, count=0, present=0. While req is still held there is no update; release then press 3 → count=1, mru=3.
6. Assert rst asynchronously between edges while in UPDATE → all outputs 0 before the next edge. Repeat scenario 2 with N_CH=8, DEPTH=8: eight distinct presses give count=8, no evict_valid, lru_id=first ID pressed.
